// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter
//   Shares one cacheline adaptor between the icache and the dcache. One
//   complete line transaction is granted at a time, with round-robin
//   fairness when both caches request in the same cycle. The granted command
//   is latched, so requester inputs are ignored until the adaptor completes.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   i_pmem_read/address           icache line read request
//   i_pmem_rdata/resp             line data and one-cycle completion to icache
//   d_pmem_read/write/address     dcache line read / write-back request
//   d_pmem_wdata                  dcache write-back data
//   d_pmem_rdata/resp             line data and one-cycle completion to dcache
//   ca_read/write/address/wdata   latched command to the adaptor
//   ca_rdata, ca_resp             adaptor read data and completion
module cacheline_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 256,
  parameter int OFFSET_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              ca_read,
  output logic              ca_write,
  output logic [ADDR_W-1:0] ca_address,
  output logic [LINE_W-1:0] ca_wdata,
  input  logic [LINE_W-1:0] ca_rdata,
  input  logic              ca_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  state_e              state_q, state_d;
  logic                last_owner_q, last_owner_d;
  logic                op_write_q, op_write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;

  logic                i_req;
  logic                d_req;
  logic                grant_i;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;
  // On contention the requester that did not own the previous transaction wins.
  assign grant_i = i_req && (!d_req || (last_owner_q == OWNER_D));

  // Read data is broadcast; only the completion strobes are owner-qualified.
  assign i_pmem_rdata = ca_rdata;
  assign d_pmem_rdata = ca_rdata;
  assign ca_address   = addr_q;
  assign ca_wdata     = wdata_q;

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    op_write_d   = op_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    ca_read      = 1'b0;
    ca_write     = 1'b0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d      = SERVE_I;
          last_owner_d = OWNER_I;
          op_write_d   = 1'b0;
          addr_d       = {i_pmem_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
          wdata_d      = '0;
        end else if (d_req) begin
          state_d      = SERVE_D;
          last_owner_d = OWNER_D;
          // A simultaneous read+write is treated as the write-back.
          op_write_d   = d_pmem_write;
          addr_d       = {d_pmem_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
          wdata_d      = d_pmem_wdata;
        end
      end
      SERVE_I: begin
        ca_read     = 1'b1;
        i_pmem_resp = ca_resp;
        if (ca_resp) state_d = IDLE;
      end
      SERVE_D: begin
        ca_read     = ~op_write_q;
        ca_write    = op_write_q;
        d_pmem_resp = ca_resp;
        if (ca_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= OWNER_I;
      op_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      op_write_q   <= op_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

endmodule

// File: tb/tb_cacheline_arbiter.sv
module tb_cacheline_arbiter;

  logic         clk;
  logic         rst;
  logic         i_pmem_read;
  logic [31:0]  i_pmem_address;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [31:0]  d_pmem_address;
  logic [255:0] d_pmem_wdata;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         ca_read;
  logic         ca_write;
  logic [31:0]  ca_address;
  logic [255:0] ca_wdata;
  logic [255:0] ca_rdata;
  logic         ca_resp;

  cacheline_arbiter #(.ADDR_W(32), .LINE_W(256), .OFFSET_W(5)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .ca_read(ca_read), .ca_write(ca_write), .ca_address(ca_address),
    .ca_wdata(ca_wdata), .ca_rdata(ca_rdata), .ca_resp(ca_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic         owner_d;
    logic [255:0] rdata;
  } resp_t;

  cmd_t  cmd_q[$];
  resp_t resp_q[$];

  int total = 0;
  int bad   = 0;

  localparam logic [255:0] RD_A = {8{32'hAAAA_AAAA}};
  localparam logic [255:0] RD_B = {8{32'h5555_5555}};
  localparam logic [255:0] RD_C = {8{32'hC0DE_0001}};
  localparam logic [255:0] WD_1 = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] WD_2 = {8{32'h1234_5678}};

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations when the DUT starts a command or completes one.
  initial begin
    logic  prev_cmd;
    cmd_t  ec;
    resp_t er;
    prev_cmd = 1'b0;
    forever begin
      @(negedge clk);
      if ((ca_read | ca_write) && !prev_cmd) begin
        if (cmd_q.size() == 0) begin
          chk("unexpected_cmd", 1'b1, 1'b0);
        end else begin
          ec = cmd_q.pop_front();
          chk("cmd_write", ca_write, ec.wr);
          chk("cmd_read", ca_read, !ec.wr);
          chk("cmd_addr", ca_address, ec.addr);
          if (ec.wr) chk("cmd_wdata", ca_wdata, ec.wdata);
        end
      end
      prev_cmd = ca_read | ca_write;
      if (i_pmem_resp || d_pmem_resp) begin
        if (resp_q.size() == 0) begin
          chk("unexpected_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
        end else begin
          er = resp_q.pop_front();
          chk("resp_i", i_pmem_resp, !er.owner_d);
          chk("resp_d", d_pmem_resp, er.owner_d);
          chk("resp_rdata", er.owner_d ? d_pmem_rdata : i_pmem_rdata, er.rdata);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {ca_read, ca_write, i_pmem_resp, d_pmem_resp}, 4'b0000);
    chk("rst_addr", ca_address, 32'h0);
    chk("rst_wdata", ca_wdata, 256'h0);
    rst = 1'b0;
  endtask

  // Adaptor model: wait for a command, complete it after dly cycles, then
  // drop the owner's request and confirm the turnaround cycle is idle.
  task automatic complete(input logic owner_d, input logic [255:0] rd, input int dly);
    int n;
    n = 0;
    while (!(ca_read | ca_write) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(ca_read | ca_write)) begin
      chk("cmd_timeout", 1'b0, 1'b1);
      return;
    end
    repeat (dly) begin @(posedge clk); #1; end
    resp_q.push_back('{owner_d: owner_d, rdata: rd});
    ca_rdata = rd;
    ca_resp  = 1'b1;
    @(posedge clk); #1;
    ca_resp  = 1'b0;
    if (owner_d) begin
      d_pmem_read  = 1'b0;
      d_pmem_write = 1'b0;
    end else begin
      i_pmem_read = 1'b0;
    end
    chk("turnaround_idle", {ca_read, ca_write}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
    ca_rdata = '0; ca_resp = 1'b0;
    do_reset();

    // Icache-only read, offset bits cleared, one-cycle grant latency.
    cmd_q.push_back('{wr: 1'b0, addr: 32'h0000_1220, wdata: 256'h0});
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1234;
    @(posedge clk); #1;
    chk("grant_latency", ca_read, 1'b1);
    complete(1'b0, RD_A, 3);

    // Simultaneous requests after reset: dcache first, icache after one idle cycle.
    do_reset();
    cmd_q.push_back('{wr: 1'b0, addr: 32'h0000_0200, wdata: 256'h0});
    cmd_q.push_back('{wr: 1'b0, addr: 32'h0000_0100, wdata: 256'h0});
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0100;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_0200;
    complete(1'b1, RD_B, 2);
    @(posedge clk); #1;
    chk("second_grant_read", ca_read, 1'b1);
    chk("second_grant_addr", ca_address, 32'h0000_0100);
    complete(1'b0, RD_C, 1);

    // Fairness: D write-back, then I, then D refill.
    cmd_q.push_back('{wr: 1'b1, addr: 32'h0000_0300, wdata: WD_1});
    cmd_q.push_back('{wr: 1'b0, addr: 32'h0000_0400, wdata: 256'h0});
    cmd_q.push_back('{wr: 1'b0, addr: 32'h0000_0300, wdata: 256'h0});
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0400;
    d_pmem_write = 1'b1; d_pmem_address = 32'h0000_0300; d_pmem_wdata = WD_1;
    complete(1'b1, RD_A, 2);
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_0300;
    complete(1'b0, RD_B, 1);
    complete(1'b1, RD_C, 1);

    // Read and write together: write wins.
    cmd_q.push_back('{wr: 1'b1, addr: 32'h0000_0840, wdata: WD_2});
    d_pmem_read = 1'b1; d_pmem_write = 1'b1;
    d_pmem_address = 32'h0000_085F; d_pmem_wdata = WD_2;
    @(posedge clk); #1;
    chk("both_ops_write", {ca_write, ca_read}, 2'b10);
    complete(1'b1, RD_A, 1);

    // Spurious ca_resp in IDLE.
    @(posedge clk); #1;
    ca_rdata = RD_B; ca_resp = 1'b1;
    #1;
    chk("idle_resp_ignored", {i_pmem_resp, d_pmem_resp}, 2'b00);
    @(posedge clk); #1;
    ca_resp = 1'b0;
    chk("idle_no_state_change", {ca_read, ca_write}, 2'b00);

    // Requester address changes mid-transaction; latched address holds.
    cmd_q.push_back('{wr: 1'b0, addr: 32'h0000_0500, wdata: 256'h0});
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0504;
    @(posedge clk); #1;
    i_pmem_address = 32'h9999_0000;
    repeat (2) begin @(posedge clk); #1; end
    chk("addr_held", ca_address, 32'h0000_0500);
    complete(1'b0, RD_C, 1);

    // Reset two cycles into SERVE_D abandons the transaction.
    cmd_q.push_back('{wr: 1'b1, addr: 32'h0000_0700, wdata: WD_2});
    d_pmem_write = 1'b1; d_pmem_address = 32'h0000_0717; d_pmem_wdata = WD_2;
    repeat (2) begin @(posedge clk); #1; end
    chk("serve_d_active", ca_write, 1'b1);
    rst = 1'b1; d_pmem_write = 1'b0;
    @(posedge clk); #1;
    chk("midrst_cmds", {ca_read, ca_write, i_pmem_resp, d_pmem_resp}, 4'b0000);
    chk("midrst_addr", ca_address, 32'h0);
    chk("midrst_wdata", ca_wdata, 256'h0);
    rst = 1'b0;
    ca_rdata = RD_A; ca_resp = 1'b1;
    #1;
    chk("late_resp_ignored", d_pmem_resp, 1'b0);
    @(posedge clk); #1;
    ca_resp = 1'b0;
    chk("late_resp_idle", {ca_read, ca_write}, 2'b00);

    repeat (3) @(posedge clk);
    #1;
    chk("cmd_q_drained", cmd_q.size(), 0);
    chk("resp_q_drained", resp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
